// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared widths, opcodes and FSM encoding for shifter_arbiter
package shifter_pkg;

    localparam int N = 16;
    localparam int C = 4;
    localparam int O = 2;

    localparam logic [O-1:0] OP_ROL = 2'b00;
    localparam logic [O-1:0] OP_SLL = 2'b01;
    localparam logic [O-1:0] OP_SRA = 2'b10;
    localparam logic [O-1:0] OP_SRL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Operands captured from the winning requester on the grant edge
    typedef struct packed {
        logic [N-1:0] data;
        logic [C-1:0] cnt;
        logic [O-1:0] op;
        logic         id;
    } txn_t;

endpackage

// File: rtl/barrelShifter.sv
// rtl/barrelShifter.sv - combinational barrel shifter (ROL, SLL, SRA, SRL)
module barrelShifter
    import shifter_pkg::*;
(
    input  logic [N-1:0] In,
    input  logic [C-1:0] Cnt,
    input  logic [O-1:0] Op,
    output logic [N-1:0] Out
);

    logic [N-1:0] rol;

    // A right shift by N yields zero, so Cnt=0 needs no special case
    assign rol = (In << Cnt) | (In >> (N - int'(Cnt)));

    always_comb begin
        Out = In;
        case (Op)
            OP_ROL:  Out = rol;
            OP_SLL:  Out = In << Cnt;
            OP_SRA:  Out = $unsigned($signed(In) >>> Cnt);
            OP_SRL:  Out = In >> Cnt;
            default: Out = In;
        endcase
    end

endmodule

// File: rtl/shifter_arbiter.sv
// rtl/shifter_arbiter.sv - two-requester arbiter over one barrel shifter; SHIFTER_ARB_FIXED_PRIO_EN selects fixed priority
module shifter_arbiter
    import shifter_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [N-1:0] in0,
    input  logic [C-1:0] cnt0,
    input  logic [O-1:0] op0,
    output logic         gnt0,
    input  logic         req1,
    input  logic [N-1:0] in1,
    input  logic [C-1:0] cnt1,
    input  logic [O-1:0] op1,
    output logic         gnt1,
    output logic [N-1:0] out,
    output logic         out_valid,
    output logic         out_id,
    input  logic         out_ready
);

    state_t       state, state_nxt;
    txn_t         lat;
    logic         last_id;
    logic         pick0;
    logic [N-1:0] shift_res;

    barrelShifter u_shift (
        .In  (lat.data),
        .Cnt (lat.cnt),
        .Op  (lat.op),
        .Out (shift_res)
    );

`ifdef SHIFTER_ARB_FIXED_PRIO_EN
    assign pick0 = req0;
`else
    // On a tie requester 0 wins only if requester 1 went last
    assign pick0 = req0 && (!req1 || last_id);
`endif

    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        case (state)
            ST_IDLE: begin
                gnt0 = pick0;
                gnt1 = req1 && !pick0;
                if (req0 || req1)
                    state_nxt = ST_SHIFT;
            end
            ST_SHIFT: state_nxt = ST_DONE;
            ST_DONE: begin
                if (out_ready)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            lat       <= '0;
            last_id   <= 1'b1;
            out       <= '0;
            out_valid <= 1'b0;
            out_id    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (gnt0) begin
                        lat     <= '{data: in0, cnt: cnt0, op: op0, id: 1'b0};
                        last_id <= 1'b0;
                    end else if (gnt1) begin
                        lat     <= '{data: in1, cnt: cnt1, op: op1, id: 1'b1};
                        last_id <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    out       <= shift_res;
                    out_id    <= lat.id;
                    out_valid <= 1'b1;
                end
                ST_DONE: begin
                    if (out_ready)
                        out_valid <= 1'b0;
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_shifter_arbiter.sv
// tb/tb_shifter_arbiter.sv - self-checking bench for shifter_arbiter with a behavioural reference model
module tb_shifter_arbiter;
    import shifter_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, out_ready;
    logic [N-1:0]  in0, in1;
    logic [C-1:0]  cnt0, cnt1;
    logic [O-1:0]  op0, op1;
    logic          gnt0, gnt1, out_valid, out_id;
    logic [N-1:0]  out;

    always #5 clk = ~clk;

    shifter_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .in0(in0), .cnt0(cnt0), .op0(op0), .gnt0(gnt0),
        .req1(req1), .in1(in1), .cnt1(cnt1), .op1(op1), .gnt1(gnt1),
        .out(out), .out_valid(out_valid), .out_id(out_id), .out_ready(out_ready)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: one transaction in flight at most, result visible two cycles after grant
    bit           m_init = 0;
    bit           m_busy, m_valid, m_last, m_id, m_out_id;
    logic [N-1:0] m_res, m_out;
    bit           e_g0, e_g1;

    logic         s_g0, s_g1, s_valid, s_id;
    logic [N-1:0] s_out;

    function automatic logic [15:0] golden(input logic [15:0] a, input int k, input logic [1:0] op);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            case (op)
                2'b00: r[(i + k) % 16] = a[i];
                2'b01: if (i + k < 16) r[i + k] = a[i];
                2'b10: r[i] = (i + k < 16) ? a[i + k] : a[15];
                default: r[i] = (i + k < 16) ? a[i + k] : 1'b0;
            endcase
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        bit w;
        @(negedge clk);
        s_g0 = gnt0; s_g1 = gnt1; s_valid = out_valid; s_id = out_id; s_out = out;
        e_g0 = 0; e_g1 = 0;
        if (!m_busy && (req0 || req1)) begin
`ifdef SHIFTER_ARB_FIXED_PRIO_EN
            w = !req0;
`else
            w = (req0 && req1) ? !m_last : req1;
`endif
            e_g0 = !w;
            e_g1 = w;
        end
        if (m_init) begin
            chk("gnt0", s_g0, e_g0);
            chk("gnt1", s_g1, e_g1);
            chk("out_valid", s_valid, m_valid);
            chk("out", s_out, m_out);
            chk("out_id", s_id, m_out_id);
        end
        @(posedge clk);
        if (rst) begin
            m_init = 1; m_busy = 0; m_valid = 0; m_last = 1;
            m_out = '0; m_out_id = 0; m_id = 0; m_res = '0;
        end else if (!m_busy) begin
            if (e_g0 || e_g1) begin
                m_busy = 1;
                m_id   = e_g1;
                m_last = e_g1;
                m_res  = e_g1 ? golden(in1, int'(cnt1), op1) : golden(in0, int'(cnt0), op0);
            end
        end else if (!m_valid) begin
            m_out = m_res; m_out_id = m_id; m_valid = 1;
        end else if (out_ready) begin
            m_valid = 0; m_busy = 0;
        end
        cyc++;
        #1;
    endtask

    task automatic drain();
        req0 = 0; req1 = 0; out_ready = 1;
        repeat (4) tick();
    endtask

    task automatic directed(input bit id, input logic [15:0] a, input logic [3:0] k,
                            input logic [1:0] op, input logic [15:0] exp, input string nm);
        int tg;
        bit got;
        tg = -100; got = 0;
        chk({nm, " model"}, golden(a, int'(k), op), exp);
        out_ready = 1;
        if (id) begin req1 = 1; in1 = a; cnt1 = k; op1 = op; end
        else    begin req0 = 1; in0 = a; cnt0 = k; op0 = op; end
        for (int n = 0; n < 12 && !got; n++) begin
            tick();
            if (id ? s_g1 : s_g0) begin
                tg = cyc;
                req0 = 0; req1 = 0;
            end
            if (s_valid) begin
                got = 1;
                chk({nm, " out"}, s_out, exp);
                chk({nm, " id"}, s_id, id);
                chk({nm, " latency"}, cyc - tg, 2);
            end
        end
        if (!got) chk({nm, " timeout"}, 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g[4], ids[4];
        int ng, ni;
        bit got;
        rst = 1; req0 = 0; req1 = 0; out_ready = 0;
        in0 = '0; in1 = '0; cnt0 = '0; cnt1 = '0; op0 = OP_ROL; op1 = OP_ROL;
        #1;
        repeat (2) tick();
        rst = 0;
        tick();
        chk("reset out", s_out, 16'h0000);
        chk("reset out_valid", s_valid, 0);
        chk("reset out_id", s_id, 0);
        chk("reset gnt0", s_g0, 0);
        chk("reset gnt1", s_g1, 0);

        directed(0, 16'h8001, 4'd1,  OP_ROL, 16'h0003, "rol0");
        directed(1, 16'h8000, 4'd4,  OP_SRA, 16'hF800, "sra1");
        directed(1, 16'h00FF, 4'd8,  OP_SLL, 16'hFF00, "sll1");
        directed(1, 16'hF000, 4'd12, OP_SRL, 16'h000F, "srl1");
        directed(1, 16'h1234, 4'd0,  OP_ROL, 16'h1234, "rol1");
        drain();

        // Both requesters held high across four transactions
        req0 = 1; req1 = 1; out_ready = 1;
        in0 = 16'h0101; cnt0 = 4'd3; op0 = OP_SLL;
        in1 = 16'h8080; cnt1 = 4'd5; op1 = OP_SRA;
        ng = 0; ni = 0;
        for (int n = 0; n < 40 && (ng < 4 || ni < 4); n++) begin
            if (ng >= 4) begin req0 = 0; req1 = 0; end
            tick();
            if (s_g0 && ng < 4) begin g[ng] = 0; ng++; end
            else if (s_g1 && ng < 4) begin g[ng] = 1; ng++; end
            if (s_valid && ni < 4) begin ids[ni] = s_id; ni++; end
        end
        chk("tie grant count", ng, 4);
        chk("tie result count", ni, 4);
        for (int i = 0; i < 4; i++) begin
`ifdef SHIFTER_ARB_FIXED_PRIO_EN
            chk($sformatf("tie grant %0d", i), g[i], 0);
            chk($sformatf("tie out_id %0d", i), ids[i], 0);
`else
            chk($sformatf("tie grant %0d", i), g[i], i % 2);
            chk($sformatf("tie out_id %0d", i), ids[i], i % 2);
`endif
        end
        drain();

        // Backpressure with requester 1 waiting
        out_ready = 0;
        req0 = 1; in0 = 16'hABCD; cnt0 = 4'd0; op0 = OP_ROL;
        got = 0;
        for (int n = 0; n < 10 && !got; n++) begin
            tick();
            if (s_g0) req0 = 0;
            got = s_valid;
        end
        chk("bp reached valid", got, 1);
        req1 = 1; in1 = 16'h0F0F; cnt1 = 4'd4; op1 = OP_SRL;
        repeat (5) begin
            tick();
            chk("bp out", s_out, 16'hABCD);
            chk("bp valid", s_valid, 1);
            chk("bp gnt1", s_g1, 0);
        end
        out_ready = 1;
        tick();
        chk("bp accept valid", s_valid, 1);
        tick();
        chk("bp after valid", s_valid, 0);
        chk("bp after gnt1", s_g1, 1);
        req1 = 0;
        drain();

        // Reset while the shifter stage holds a transaction
        req0 = 1; in0 = 16'h1111; cnt0 = 4'd2; op0 = OP_SLL;
        got = 0;
        for (int n = 0; n < 6 && !got; n++) begin
            tick();
            got = s_g0;
        end
        chk("rst grant seen", got, 1);
        req0 = 0; rst = 1;
        tick();
        rst = 0; req0 = 1; req1 = 1;
        in1 = 16'h2222; cnt1 = 4'd1; op1 = OP_ROL;
        tick();
        chk("rst out_valid", s_valid, 0);
        chk("rst out", s_out, 16'h0000);
        chk("rst gnt0", s_g0, 1);
        chk("rst gnt1", s_g1, 0);
        drain();

        // Randomized stress against the model
        for (int n = 0; n < 5000; n++) begin
            tick();
            if (s_g0 || !req0) begin
                req0 = (($urandom % 3) == 0) || (s_g0 && ($urandom % 2 == 0));
                in0 = 16'($urandom); cnt0 = 4'($urandom); op0 = 2'($urandom);
            end
            if (s_g1 || !req1) begin
                req1 = (($urandom % 3) == 0) || (s_g1 && ($urandom % 2 == 0));
                in1 = 16'($urandom); cnt1 = 4'($urandom); op1 = 2'($urandom);
            end
            out_ready = ($urandom % 4) != 0;
            rst = ($urandom % 300) == 0;
        end
        rst = 0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
